// File: rtl/bic_pkg.sv
// rtl/bic_pkg.sv - shared types and helpers for the bus-invert transmit driver
package bic_pkg;
  localparam int BUS_W = 8;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, ERR} state_t;

  function automatic logic [3:0] popcount9(input logic [8:0] x);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 9; i++) n = n + {3'b000, x[i]};
    return n;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, max}) return max;
    return s[31:0];
  endfunction
endpackage

// File: rtl/bic_fifo.sv
// rtl/bic_fifo.sv - DEPTH x W synchronous FIFO holding {invert, data} words
module bic_fifo
  import bic_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = BUS_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full     = count_q == (AW+1)'(DEPTH);
  assign empty    = count_q == '0;
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // DEPTH is a power of two, so pointers wrap on their own
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/bic_bus_driver.sv
// rtl/bic_bus_driver.sv - drives encoded words onto the bus with two-phase handshake and toggle stats
module bic_bus_driver
  import bic_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] in_data,
  input  logic             in_invert,
  output logic [BUS_W-1:0] bus_data,
  output logic             bus_invert,
  output logic             bus_strobe,
  input  logic             bus_ack,
  input  logic             clear_stats,
  input  logic             clear_err,
  output logic             err,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] tog_coded,
  output logic [CNT_W-1:0] tog_raw
);
  localparam int          CW         = $clog2(DEPTH) + 1;
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
  localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF >> (32 - CNT_W);

  state_t           state_q, state_d;
  logic [15:0]      timer_q, timer_d;
  logic [BUS_W-1:0] bus_data_q, bus_data_d;
  logic             bus_invert_q, bus_invert_d;
  logic             bus_strobe_q, bus_strobe_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic [CNT_W-1:0] tog_coded_q, tog_coded_d;
  logic [CNT_W-1:0] tog_raw_q, tog_raw_d;

  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty, launch;
  logic [BUS_W:0]   head;
  logic [BUS_W-1:0] raw_p, raw_n;
  logic [3:0]       coded_delta, raw_delta;

  bic_fifo #(.DEPTH(DEPTH), .W(BUS_W + 1)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid && !fifo_full),
    .push_data ({in_invert, in_data}),
    .pop       (launch),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign in_ready = fifo_count != CW'(DEPTH);

  // Toggle statistics compare the word being launched against what the bus holds now
  assign raw_p       = bus_data_q ^ {BUS_W{bus_invert_q}};
  assign raw_n       = head[BUS_W-1:0] ^ {BUS_W{head[BUS_W]}};
  assign coded_delta = popcount9({bus_invert_q ^ head[BUS_W], bus_data_q ^ head[BUS_W-1:0]});
  assign raw_delta   = popcount9({1'b0, raw_p ^ raw_n});

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bus_data_d   = bus_data_q;
    bus_invert_d = bus_invert_q;
    bus_strobe_d = bus_strobe_q;
    err_d        = err_q;
    word_count_d = word_count_q;
    tog_coded_d  = tog_coded_q;
    tog_raw_d    = tog_raw_q;
    launch       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          launch  = 1'b1;
          state_d = WAIT_ACK;
          timer_d = '0;
        end
      end
      WAIT_ACK: begin
        // A matching ack beats a timer expiring in the same cycle
        if (bus_ack == bus_strobe_q) begin
          if (!fifo_empty) begin
            launch  = 1'b1;
            timer_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ERR: begin
        if (clear_err) begin
          state_d      = IDLE;
          err_d        = 1'b0;
          bus_strobe_d = bus_ack;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      bus_data_d   = head[BUS_W-1:0];
      bus_invert_d = head[BUS_W];
      bus_strobe_d = ~bus_strobe_q;
    end

    if (clear_stats) begin
      word_count_d = '0;
      tog_coded_d  = '0;
      tog_raw_d    = '0;
    end else if (launch) begin
      word_count_d = CNT_W'(sat_add(32'(word_count_q), 32'd1, CNT_MAX));
      tog_coded_d  = CNT_W'(sat_add(32'(tog_coded_q), 32'(coded_delta), CNT_MAX));
      tog_raw_d    = CNT_W'(sat_add(32'(tog_raw_q), 32'(raw_delta), CNT_MAX));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      bus_data_q   <= '0;
      bus_invert_q <= 1'b0;
      bus_strobe_q <= 1'b0;
      err_q        <= 1'b0;
      word_count_q <= '0;
      tog_coded_q  <= '0;
      tog_raw_q    <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bus_data_q   <= bus_data_d;
      bus_invert_q <= bus_invert_d;
      bus_strobe_q <= bus_strobe_d;
      err_q        <= err_d;
      word_count_q <= word_count_d;
      tog_coded_q  <= tog_coded_d;
      tog_raw_q    <= tog_raw_d;
    end
  end

  assign bus_data   = bus_data_q;
  assign bus_invert = bus_invert_q;
  assign bus_strobe = bus_strobe_q;
  assign err        = err_q;
  assign word_count = word_count_q;
  assign tog_coded  = tog_coded_q;
  assign tog_raw    = tog_raw_q;
endmodule
